// File: rtl/fire_pkg.sv
// Shared types and constants for the fireball pool: channel states,
// USB key codes and the visible screen width.
package fire_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    MOVE  = 2'd2
  } fire_state_e;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_CLEAR = 8'h2C;

  localparam logic [9:0] SCREEN_W = 10'd640;

  // True when any of the four keycode bytes matches the given key.
  function automatic logic key_held(input logic [31:0] codes, input logic [7:0] key);
    logic found;
    found = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (codes[8*b +: 8] == key) found = 1'b1;
    end
    return found;
  endfunction

endpackage

// File: rtl/fire_channel.sv
// One fireball: IDLE/ARMED/MOVE state machine with homing, scroll
// compensation, despawn and hit detection, all advanced on tick cycles.
module fire_channel
  import fire_pkg::*;
#(
  parameter int STEP   = 2,
  parameter int SCROLL = 8,
  parameter int HOME_X = 340,
  parameter int HOME_Y = 320
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       tick_i,
  input  logic       arm_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic [9:0] mario_x_i,
  input  logic [9:0] mario_y_i,
  input  logic [9:0] mario_sx_i,
  output logic       idle_o,
  output logic       active_o,
  output logic       hit_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o
);

  localparam logic [9:0] STEP_V   = 10'(STEP);
  localparam logic [9:0] SCROLL_V = 10'(SCROLL);

  fire_state_e state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [9:0]  marioRight, yAhead, xNew, yNew;
  logic        behind, despawn, hitCond;

  // Candidate motion for this tick, from pre-update position (10-bit wrap).
  always_comb begin
    marioRight = mario_x_i + mario_sx_i;
    yAhead     = y_q + STEP_V;
    behind     = (marioRight <= (x_q - STEP_V));
    xNew       = x_q;
    if (behind) xNew = xNew - STEP_V;
    if (right_i) xNew = xNew - SCROLL_V;
    else if (left_i) xNew = xNew + SCROLL_V;
    if (mario_y_i > yAhead) yNew = y_q + STEP_V;
    else if (mario_y_i < yAhead) yNew = y_q - STEP_V;
    else yNew = y_q;
    despawn = (xNew >= SCREEN_W);
    hitCond = !behind && (mario_y_i == yAhead);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    hit_o   = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      x_d     = 10'(HOME_X);
      y_d     = 10'(HOME_Y);
    end else if (tick_i) begin
      case (state_q)
        IDLE:  if (arm_i) state_d = ARMED;
        ARMED: state_d = MOVE;
        MOVE: begin
          if (despawn || hitCond) begin
            state_d = IDLE;
            x_d     = 10'(HOME_X);
            y_d     = 10'(HOME_Y);
            hit_o   = !despawn;
          end else begin
            x_d = xNew;
            y_d = yNew;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      x_q     <= 10'(HOME_X);
      y_q     <= 10'(HOME_Y);
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign idle_o   = (state_q == IDLE);
  assign active_o = (state_q == ARMED) || (state_q == MOVE);
  assign x_o      = x_q;
  assign y_o      = y_q;

endmodule

// File: rtl/fire_pool.sv
// Fireball pool top: tick divider, spawn arbiter with cooldown, penalty
// accumulator and the per-pixel render priority mux over all channels.
module fire_pool
  import fire_pkg::*;
#(
  parameter int N_FIRE      = 4,
  parameter int TICK_DIV    = 3_000_000,
  parameter int STEP        = 2,
  parameter int SCROLL      = 8,
  parameter int SPAWN_LO    = 292,
  parameter int SPAWN_HI    = 360,
  parameter int SPAWN_GAP   = 6,
  parameter int HOME_X      = 340,
  parameter int HOME_Y      = 320,
  parameter int SIZE_X      = 48,
  parameter int SIZE_Y      = 16,
  parameter int SCALE_SH    = 1,
  parameter int ROM_BASE_X  = 112,
  parameter int ROM_BASE_Y  = 99,
  parameter int ROM_STRIDE  = 188,
  parameter int HIT_PENALTY = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       keycode,
  input  logic [8:0]        BG_step,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        MarioX,
  input  logic [9:0]        MarioY,
  input  logic [9:0]        MarioS_X,
  output logic              is_fire,
  output logic [18:0]       fire_rom_addr,
  output logic [N_FIRE-1:0] active_mask,
  output logic              fire_hit,
  output logic [8:0]        dead_times
);

  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CDW = $clog2(SPAWN_GAP + 2);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CDW-1:0]    cool_q, cool_d;
  logic [8:0]        dead_q, dead_d;
  logic              hit_q, hit_d;
  logic              tick, clear, left, right, inWindow, spawnOk, found;
  logic [N_FIRE-1:0] idleVec, activeVec, hitVec, armVec;
  logic [9:0]        chX [N_FIRE];
  logic [9:0]        chY [N_FIRE];
  logic [3:0]        hitCount;
  logic [11:0]       penaltySum;

  assign tick     = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d    = tick ? '0 : cnt_q + 1'b1;
  assign clear    = key_held(keycode, KEY_CLEAR);
  assign left     = key_held(keycode, KEY_LEFT);
  assign right    = key_held(keycode, KEY_RIGHT);
  assign inWindow = (BG_step > 9'(SPAWN_LO)) && (BG_step < 9'(SPAWN_HI));
  assign spawnOk  = tick && !clear && inWindow && (cool_q == '0);

  for (genvar g = 0; g < N_FIRE; g++) begin : g_ch
    fire_channel #(
      .STEP(STEP), .SCROLL(SCROLL), .HOME_X(HOME_X), .HOME_Y(HOME_Y)
    ) u_ch (
      .clk_i(Clk), .reset_i(Reset), .clear_i(clear), .tick_i(tick),
      .arm_i(armVec[g] && spawnOk), .left_i(left), .right_i(right),
      .mario_x_i(MarioX), .mario_y_i(MarioY), .mario_sx_i(MarioS_X),
      .idle_o(idleVec[g]), .active_o(activeVec[g]), .hit_o(hitVec[g]),
      .x_o(chX[g]), .y_o(chY[g])
    );
  end

  // Lowest-index idle channel is the spawn candidate; busy pool leaves cooldown alone.
  always_comb begin
    armVec = '0;
    found  = 1'b0;
    for (int i = 0; i < N_FIRE; i++) begin
      if (idleVec[i] && !found) begin
        armVec[i] = 1'b1;
        found     = 1'b1;
      end
    end
    cool_d = cool_q;
    if (clear) cool_d = '0;
    else if (spawnOk && found) cool_d = CDW'(SPAWN_GAP);
    else if (tick && (cool_q != '0)) cool_d = cool_q - 1'b1;
  end

  always_comb begin
    hitCount = '0;
    for (int i = 0; i < N_FIRE; i++) hitCount = hitCount + {3'b0, hitVec[i]};
    penaltySum = {3'b0, dead_q} + 12'(hitCount) * 12'(HIT_PENALTY);
    dead_d     = dead_q;
    hit_d      = 1'b0;
    if (clear) dead_d = '0;
    else if (|hitVec) begin
      dead_d = (penaltySum > 12'd511) ? 9'd511 : penaltySum[8:0];
      hit_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q  <= '0;
      cool_q <= '0;
      dead_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cool_q <= cool_d;
      dead_q <= dead_d;
      hit_q  <= hit_d;
    end
  end

  logic [9:0]  relX, relY;
  logic [18:0] colTerm, rowTerm;

  // Render mux: first covering channel in index order owns the pixel.
  always_comb begin
    is_fire = 1'b0;
    relX    = '0;
    relY    = '0;
    for (int i = 0; i < N_FIRE; i++) begin
      if (!is_fire && activeVec[i] &&
          ({1'b0, DrawX} >= {1'b0, chX[i]}) && ({1'b0, DrawX} < {1'b0, chX[i]} + 11'(SIZE_X)) &&
          ({1'b0, DrawY} >= {1'b0, chY[i]}) && ({1'b0, DrawY} < {1'b0, chY[i]} + 11'(SIZE_Y))) begin
        is_fire = 1'b1;
        relX    = DrawX - chX[i];
        relY    = DrawY - chY[i];
      end
    end
    colTerm       = 19'(relX >> SCALE_SH) + 19'(ROM_BASE_X);
    rowTerm       = (19'(relY >> SCALE_SH) + 19'(ROM_BASE_Y)) * 19'(ROM_STRIDE);
    fire_rom_addr = is_fire ? (colTerm + rowTerm) : '0;
  end

  assign active_mask = activeVec;
  assign fire_hit    = hit_q;
  assign dead_times  = dead_q;

endmodule

// File: tb/tb_fire_pool.sv
// Directed bench for fire_pool with a 4-cycle tick: spawn, homing, scroll,
// despawn, hits with saturation, clear and reset-over-tick.
module tb_fire_pool;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] keycode;
  logic [8:0]  BG_step;
  logic [9:0]  DrawX, DrawY, MarioX, MarioY, MarioS_X;
  logic        is_fire;
  logic [18:0] fire_rom_addr;
  logic [3:0]  active_mask;
  logic        fire_hit;
  logic [8:0]  dead_times;

  int checks   = 0;
  int failures = 0;
  int cntM     = 0;

  always #5 Clk = ~Clk;

  fire_pool #(.TICK_DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .BG_step(BG_step),
    .DrawX(DrawX), .DrawY(DrawY), .MarioX(MarioX), .MarioY(MarioY),
    .MarioS_X(MarioS_X), .is_fire(is_fire), .fire_rom_addr(fire_rom_addr),
    .active_mask(active_mask), .fire_hit(fire_hit), .dead_times(dead_times)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] kc, input logic [8:0] bg,
                               input logic [9:0] mx, input logic [9:0] my, input logic [9:0] msx);
    keycode  = kc;
    BG_step  = bg;
    MarioX   = mx;
    MarioY   = my;
    MarioS_X = msx;
  endtask

  // One clock edge, tracking the divider phase, then settle past the edge.
  task automatic cycle();
    @(posedge Clk);
    if (Reset) cntM = 0;
    else cntM = (cntM == 3) ? 0 : cntM + 1;
    #1;
  endtask

  task automatic tickStep();
    bit wasTick;
    do begin
      wasTick = (cntM == 3);
      cycle();
    end while (!wasTick);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    DrawX = 10'd0;
    DrawY = 10'd0;
    applyStimulus(32'h0, 9'd0, 10'd600, 10'd0, 10'd16);
    cycle();
    cycle();
    checkOutput("rst_mask", 32'(active_mask), 32'd0);
    checkOutput("rst_dead", 32'(dead_times), 32'd0);
    checkOutput("rst_hit", 32'(fire_hit), 32'd0);
    checkOutput("rst_isfire", 32'(is_fire), 32'd0);
    checkOutput("rst_addr", 32'(fire_rom_addr), 32'd0);
    Reset = 1'b0;

    // Spawn window is exclusive at 292.
    applyStimulus(32'h0, 9'd292, 10'd600, 10'd0, 10'd16);
    tickStep();
    tickStep();
    checkOutput("no_spawn_292", 32'(active_mask), 32'd0);
    BG_step = 9'd300;
    tickStep();
    checkOutput("spawn_ch0", 32'(active_mask), 32'd1);
    DrawX = 10'd340; DrawY = 10'd320; #1;
    checkOutput("render_origin", 32'(fire_rom_addr), 32'd18724);
    DrawX = 10'd387; DrawY = 10'd335; #1;
    checkOutput("render_corner", 32'(fire_rom_addr), 32'd20063);
    DrawX = 10'd388; #1;
    checkOutput("render_outside", 32'(is_fire), 32'd0);
    checkOutput("render_out_addr", 32'(fire_rom_addr), 32'd0);
    repeat (6) tickStep();
    checkOutput("cooldown_hold", 32'(active_mask), 32'd1);
    tickStep();
    checkOutput("spawn_ch1", 32'(active_mask), 32'd3);

    // Homing from home position with Mario behind and below.
    applyStimulus(32'h2C, 9'd0, 10'd100, 10'd330, 10'd16);
    cycle();
    checkOutput("clear_mask", 32'(active_mask), 32'd0);
    applyStimulus(32'h0, 9'd300, 10'd100, 10'd330, 10'd16);
    tickStep();
    BG_step = 9'd0;
    tickStep();
    checkOutput("move_x0", 32'(dut.g_ch[0].u_ch.x_q), 32'd340);
    for (int k = 1; k <= 5; k++) begin
      tickStep();
      checkOutput("home_x", 32'(dut.g_ch[0].u_ch.x_q), 32'(340 - 2*k));
      checkOutput("home_y", 32'(dut.g_ch[0].u_ch.y_q), 32'((k < 5) ? 320 + 2*k : 328));
      if (k == 1) begin
        DrawX = 10'd338; DrawY = 10'd322; #1;
        checkOutput("render_moved", 32'(fire_rom_addr), 32'd18724);
        DrawX = 10'd337; #1;
        checkOutput("render_left_edge", 32'(is_fire), 32'd0);
      end
    end

    // Scroll: both keys -> right wins; left alone -> +SCROLL.
    applyStimulus(32'h0407_0000, 9'd0, 10'd600, 10'd500, 10'd16);
    tickStep();
    checkOutput("scroll_both", 32'(dut.g_ch[0].u_ch.x_q), 32'd322);
    keycode = 32'h0000_0004;
    tickStep();
    checkOutput("scroll_left", 32'(dut.g_ch[0].u_ch.x_q), 32'd330);
    checkOutput("scroll_y", 32'(dut.g_ch[0].u_ch.y_q), 32'd332);

    // Walk x down to 4, then wrap below zero.
    applyStimulus(32'h0, 9'd0, 10'd100, 10'd1000, 10'd16);
    repeat (3) tickStep();
    checkOutput("pre_wrap_x", 32'(dut.g_ch[0].u_ch.x_q), 32'd324);
    applyStimulus(32'h07, 9'd0, 10'd600, 10'd1000, 10'd16);
    repeat (40) tickStep();
    checkOutput("wrap_x4", 32'(dut.g_ch[0].u_ch.x_q), 32'd4);
    checkOutput("wrap_active", 32'(active_mask), 32'd1);
    tickStep();
    checkOutput("wrap_despawn", 32'(active_mask), 32'd0);
    checkOutput("wrap_nohit", 32'(fire_hit), 32'd0);
    checkOutput("wrap_dead", 32'(dead_times), 32'd0);
    checkOutput("wrap_home_x", 32'(dut.g_ch[0].u_ch.x_q), 32'd340);

    // Two channels brought into phase, then hit together.
    applyStimulus(32'h2C, 9'd0, 10'd600, 10'd321, 10'd16);
    cycle();
    applyStimulus(32'h0, 9'd300, 10'd600, 10'd321, 10'd16);
    tickStep();
    BG_step = 9'd0;
    repeat (7) tickStep();
    BG_step = 9'd300;
    tickStep();
    checkOutput("dual_spawn", 32'(active_mask), 32'd3);
    BG_step = 9'd0;
    tickStep();
    tickStep();
    checkOutput("dual_y0", 32'(dut.g_ch[0].u_ch.y_q), 32'd318);
    checkOutput("dual_y1", 32'(dut.g_ch[1].u_ch.y_q), 32'd318);
    MarioY = 10'd320;
    tickStep();
    checkOutput("dual_hit", 32'(fire_hit), 32'd1);
    checkOutput("dual_dead", 32'(dead_times), 32'd20);
    checkOutput("dual_mask", 32'(active_mask), 32'd0);
    cycle();
    checkOutput("hit_pulse_end", 32'(fire_hit), 32'd0);

    // Single-channel hits every 7 ticks until saturation.
    applyStimulus(32'h2C, 9'd300, 10'd600, 10'd322, 10'd16);
    cycle();
    keycode = 32'h0;
    repeat (51 * 7) tickStep();
    checkOutput("sat_510", 32'(dead_times), 32'd510);
    repeat (7) tickStep();
    checkOutput("sat_511", 32'(dead_times), 32'd511);
    tickStep();
    checkOutput("midflight_mask", 32'(active_mask), 32'd1);
    keycode = 32'h002C_0000;
    cycle();
    checkOutput("clear_mid_mask", 32'(active_mask), 32'd0);
    checkOutput("clear_mid_dead", 32'(dead_times), 32'd0);

    // Reset lands on the tick that would have produced a hit.
    keycode = 32'h0;
    repeat (3) tickStep();
    checkOutput("pre_rst_dead", 32'(dead_times), 32'd10);
    repeat (5) tickStep();
    checkOutput("pre_rst_mask", 32'(active_mask), 32'd1);
    tickStep();
    while (cntM != 3) cycle();
    Reset = 1'b1;
    cycle();
    checkOutput("rst_tick_mask", 32'(active_mask), 32'd0);
    checkOutput("rst_tick_dead", 32'(dead_times), 32'd0);
    checkOutput("rst_tick_hit", 32'(fire_hit), 32'd0);
    Reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
